// File: rtl/usb_pd_clk_pkg.sv
// Shared types and constants for the USB-PD clock manager: FSM state encoding
// and default tick increments for a 30 MHz PLL with a 24-bit accumulator.
package usb_pd_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2,
    LOST      = 2'd3
  } pd_state_e;

  localparam logic [23:0] INC_BMC_600K = 24'd335544;
  localparam logic [23:0] INC_TMR_1M   = 24'd559241;

endpackage

// File: rtl/usb_pd_tick_acc.sv
// Single-channel phase accumulator; tick is the registered carry of the wrapping add.
module usb_pd_tick_acc #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [ACC_W-1:0] inc,
  output logic             tick
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             tick_q, tick_d;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, inc};
    acc_d  = '0;
    tick_d = 1'b0;
    // Disabling drops the phase so a re-enable starts cleanly from zero.
    if (en) begin
      acc_d  = sum[ACC_W-1:0];
      tick_d = sum[ACC_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/usb_pd_clk_mgr.sv
// PLL lock supervisor, core reset generator and NUM_CH fractional tick sources.
// Optional lock-low glitch filter in RUN: USB_PD_CLK_MGR_GLITCH_FILT_EN.
module usb_pd_clk_mgr
  import usb_pd_clk_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ACC_W    = 24,
  parameter int LOCK_CYC = 1024,
  parameter int HOLD_CYC = 64,
  parameter int FILT_CYC = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pll_lock,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*ACC_W-1:0] ch_inc,
  output logic                    sys_rst_n,
  output logic                    locked,
  output logic [NUM_CH-1:0]       tick,
  output logic [7:0]              lost_cnt
);

  localparam int CNT_MAX = (LOCK_CYC > HOLD_CYC) ? LOCK_CYC : HOLD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  logic [1:0]       sync_q;
  logic             lk_s;
  pd_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       lost_q, lost_d;
  logic             run_q, run_d;
  logic             loss;

  assign lk_s = sync_q[1];

`ifdef USB_PD_CLK_MGR_GLITCH_FILT_EN
  localparam int FLT_W = $clog2(FILT_CYC) + 1;
  logic [FLT_W-1:0] filt_q, filt_d;

  assign loss = !lk_s && (filt_q == FLT_W'(FILT_CYC - 1));

  always_comb begin
    filt_d = '0;
    if (state_q == RUN && !lk_s && !loss) filt_d = filt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) filt_q <= '0;
    else        filt_q <= filt_d;
  end
`else
  logic unused_filt;
  assign unused_filt = (FILT_CYC > 0);
  assign loss        = !lk_s;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lost_d  = lost_q;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lk_s) state_d = STABLE;
      end
      STABLE: begin
        // A drop before qualification is just a false start, not a loss.
        if (!lk_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_CYC - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (loss) begin
          state_d = LOST;
          if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
        end
      end
      LOST: begin
        if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    run_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      lost_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], pll_lock};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lost_q  <= lost_d;
      run_q   <= run_d;
    end
  end

  assign sys_rst_n = run_q;
  assign locked    = run_q;
  assign lost_cnt  = lost_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    usb_pd_tick_acc #(.ACC_W(ACC_W)) u_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (run_q & ch_en[g]),
      .inc   (ch_inc[g*ACC_W +: ACC_W]),
      .tick  (tick[g])
    );
  end

endmodule
